// File: rtl/avg_pool2x2_stream.sv
// avg_pool2x2_stream: 2x2 stride-2 FP16 pooling over a raster stream, mean or max
module avg (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  output logic [15:0] y
);
  logic signed [43:0] sum;
  logic [42:0] mag;
  logic [42:0] q;
  logic [5:0] p;
  logic [5:0] s;
  logic rnd;
  logic [16:0] bits;
  function automatic logic signed [43:0] fix(input logic [15:0] x);
    logic [43:0] m;
    m = (x[14:10] == 5'd0) ? 44'(x[9:0]) : (44'({1'b1, x[9:0]}) << (x[14:10] - 5'd1));
    return x[15] ? -$signed(m) : $signed(m);
  endfunction
  // exact fixed-point sum in units of 2^-24, divided by 4 by reinterpreting as 2^-26, then one RNE
  always_comb begin
    sum = fix(a) + fix(b) + fix(c) + fix(d);
    mag = sum[43] ? 43'(-sum) : 43'(sum);
    p = '0;
    for (int i = 0; i < 43; i++) p = mag[i] ? 6'(i) : p;
    s = (p >= 6'd12) ? p - 6'd10 : 6'd2;
    q = mag >> s;
    rnd = mag[s - 6'd1] && (q[0] || |(mag & ((43'd1 << (s - 6'd1)) - 43'd1)));
    bits = 17'({(p >= 6'd12) ? 5'(p - 6'd12) : 5'd0, 10'd0}) + 17'(q) + 17'(rnd);
    y = (bits >= 17'h07c00) ? {sum[43], 15'h7c00} : {sum[43], bits[14:0]};
  end
endmodule

module avg_pool2x2_stream #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int POOL_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [15:0] line_q [IMG_W];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [15:0] left_q, left_d, out_data_q, out_data_d;
  logic [15:0] win_a, win_b, avg_y, max_y;
  logic out_valid_q, out_valid_d, last_q, last_d;
  logic acc, win, last_col, last_row;
  function automatic logic signed [16:0] key(input logic [15:0] x);
    return x[15] ? -$signed({2'b00, x[14:0]}) : $signed({2'b00, x[14:0]});
  endfunction
  avg u_avg (.a(win_a), .b(win_b), .c(left_q), .d(in_data), .y(avg_y));
  always_comb begin
    in_ready = !rst && (!out_valid_q || out_ready);
    acc = in_valid && in_ready;
    last_col = col_q == CW'(IMG_W - 1);
    last_row = row_q == RW'(IMG_H - 1);
    win = acc && row_q[0] && col_q[0];
    win_a = line_q[col_q & ~CW'(1)];
    win_b = line_q[col_q];
    max_y = win_a;
    max_y = (key(win_b) > key(max_y)) ? win_b : max_y;
    max_y = (key(left_q) > key(max_y)) ? left_q : max_y;
    max_y = (key(in_data) > key(max_y)) ? in_data : max_y;
    col_d = acc ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_d = (acc && last_col) ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    left_d = (acc && row_q[0] && !col_q[0]) ? in_data : left_q;
    out_valid_d = win || (out_valid_q && !out_ready);
    out_data_d = win ? ((POOL_MODE == 1) ? max_y : avg_y) : out_data_q;
    last_d = win ? (last_row && last_col) : last_q;
    frame_done = out_valid_q && out_ready && last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      left_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      left_q <= left_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      last_q <= last_d;
    end
  end
  always_ff @(posedge clk) if (acc && !row_q[0]) line_q[col_q] <= in_data;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
endmodule
